// File: rtl/hmc_link_rf.sv
// HMC link register file: status, control and saturating traffic counters.
// Accesses complete exactly two edges after the strobe edge.

module hmc_link_rf #(
    parameter int FPW           = 4,
    parameter int LOG_NUM_LANES = 3,
    parameter int HMC_RF_AWIDTH = 4,
    parameter int HMC_RF_RWIDTH = 64,
    parameter int HMC_RF_WWIDTH = 64,
    parameter int CNT_WIDTH     = 48
) (
    input  logic                     clk_hmc,
    input  logic                     res_n_hmc,
    input  logic                     s_axis_tx_TVALID,
    input  logic                     s_axis_tx_TREADY,
    input  logic                     m_axis_rx_TVALID,
    input  logic                     m_axis_rx_TREADY,
    input  logic                     phy_tx_ready,
    input  logic                     phy_rx_ready,
    input  logic                     link_up,
    input  logic                     FERR_N,
    input  logic [HMC_RF_AWIDTH-1:0] rf_address,
    input  logic                     rf_read_en,
    input  logic                     rf_write_en,
    input  logic [HMC_RF_WWIDTH-1:0] rf_write_data,
    output logic [HMC_RF_RWIDTH-1:0] rf_read_data,
    output logic                     rf_invalid_address,
    output logic                     rf_access_complete,
    output logic                     ctrl_p_rst_n,
    output logic                     ctrl_init_cont_set,
    output logic                     ctrl_set_sleep,
    output logic                     ctrl_scrambler_disable
);

    typedef logic [HMC_RF_AWIDTH-1:0] addr_t;
    typedef logic [HMC_RF_RWIDTH-1:0] rdata_t;
    typedef logic [CNT_WIDTH-1:0]     cnt_t;

    localparam addr_t A_STATUS   = addr_t'(4'h0);
    localparam addr_t A_RSVD1    = addr_t'(4'h1);
    localparam addr_t A_CONTROL  = addr_t'(4'h2);
    localparam addr_t A_TX_BEATS = addr_t'(4'h3);
    localparam addr_t A_RX_BEATS = addr_t'(4'h4);
    localparam addr_t A_TX_STALL = addr_t'(4'h5);
    localparam addr_t A_RX_STALL = addr_t'(4'h6);
    localparam addr_t A_FERR_EVT = addr_t'(4'h7);
    localparam addr_t A_CLEAR    = addr_t'(4'h8);
    localparam addr_t A_CYCLES   = addr_t'(4'h9);
    localparam addr_t A_INFO     = addr_t'(4'hA);
    localparam addr_t A_RSVDB    = addr_t'(4'hB);
    localparam addr_t A_RSVDC    = addr_t'(4'hC);

    localparam logic [7:0] FPW_B   = 8'(FPW);
    localparam logic [7:0] LANES_B = 8'(LOG_NUM_LANES);

    logic   ferr_q;
    cnt_t   tx_beats_q;
    cnt_t   rx_beats_q;
    cnt_t   tx_stalls_q;
    cnt_t   rx_stalls_q;
    cnt_t   ferr_events_q;
    cnt_t   cycles_q;
    logic [3:0] control_q;

    // first access stage: request captured with its read snapshot
    logic   req_vld_q;
    logic   req_rd_q;
    logic   req_wr_q;
    logic   req_inv_q;
    addr_t  req_addr_q;
    logic [3:0] req_wdata_q;
    rdata_t req_snap_q;

    logic   rd_ok;
    logic   wr_ok;
    rdata_t rd_mux;
    logic   req_inv;

    logic   tx_hs;
    logic   rx_hs;
    logic   tx_stall;
    logic   rx_stall;
    logic   ferr_fall;

    logic   wr_commit;
    logic   rd_commit;
    logic   ctrl_wr;
    logic   cnt_clr;

    logic   unused_wdata;

    assign unused_wdata = ^rf_write_data[HMC_RF_WWIDTH-1:4];

    function automatic cnt_t sat_inc(input cnt_t c, input logic inc);
        return c + cnt_t'(inc && !(&c));
    endfunction

    assign tx_hs     = s_axis_tx_TVALID & s_axis_tx_TREADY;
    assign rx_hs     = m_axis_rx_TVALID & m_axis_rx_TREADY;
    assign tx_stall  = s_axis_tx_TVALID & ~s_axis_tx_TREADY;
    assign rx_stall  = m_axis_rx_TVALID & ~m_axis_rx_TREADY;
    assign ferr_fall = ferr_q & ~FERR_N;

    // address decode: readable/writable and current register value
    always_comb begin
        rd_ok  = 1'b0;
        wr_ok  = 1'b0;
        rd_mux = '0;
        case (rf_address)
            A_STATUS: begin
                rd_ok  = 1'b1;
                rd_mux = rdata_t'({~FERR_N, link_up,
                                   phy_rx_ready, phy_tx_ready});
            end
            A_RSVD1: rd_ok = 1'b1;
            A_CONTROL: begin
                rd_ok  = 1'b1;
                wr_ok  = 1'b1;
                rd_mux = rdata_t'(control_q);
            end
            A_TX_BEATS: begin
                rd_ok  = 1'b1;
                rd_mux = rdata_t'(tx_beats_q);
            end
            A_RX_BEATS: begin
                rd_ok  = 1'b1;
                rd_mux = rdata_t'(rx_beats_q);
            end
            A_TX_STALL: begin
                rd_ok  = 1'b1;
                rd_mux = rdata_t'(tx_stalls_q);
            end
            A_RX_STALL: begin
                rd_ok  = 1'b1;
                rd_mux = rdata_t'(rx_stalls_q);
            end
            A_FERR_EVT: begin
                rd_ok  = 1'b1;
                rd_mux = rdata_t'(ferr_events_q);
            end
            A_CLEAR: wr_ok = 1'b1;
            A_CYCLES: begin
                rd_ok  = 1'b1;
                rd_mux = rdata_t'(cycles_q);
            end
            A_INFO: begin
                rd_ok  = 1'b1;
                rd_mux = rdata_t'({LANES_B, FPW_B});
            end
            A_RSVDB: rd_ok = 1'b1;
            A_RSVDC: rd_ok = 1'b1;
            default: begin
                rd_ok = 1'b0;
                wr_ok = 1'b0;
            end
        endcase
    end

    assign req_inv = (rf_read_en & rf_write_en)
                   | (rf_read_en & ~rd_ok)
                   | (rf_write_en & ~wr_ok);

    assign wr_commit = req_vld_q & req_wr_q & ~req_inv_q;
    assign rd_commit = req_vld_q & req_rd_q & ~req_inv_q;
    assign ctrl_wr   = wr_commit & (req_addr_q == A_CONTROL);
    assign cnt_clr   = wr_commit & (req_addr_q == A_CLEAR)
                     & req_wdata_q[0];

    // capture strobe, decode result and read snapshot
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            req_vld_q   <= 1'b0;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            req_inv_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_snap_q  <= '0;
        end else begin
            req_vld_q   <= rf_read_en | rf_write_en;
            req_rd_q    <= rf_read_en;
            req_wr_q    <= rf_write_en;
            req_inv_q   <= req_inv;
            req_addr_q  <= rf_address;
            req_wdata_q <= rf_write_data[3:0];
            req_snap_q  <= rd_mux;
        end
    end

    // completion: pulse, status and read data (held between accesses)
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            rf_access_complete <= 1'b0;
            rf_invalid_address <= 1'b0;
            rf_read_data       <= '0;
        end else begin
            rf_access_complete <= req_vld_q;
            if (req_vld_q) begin
                rf_invalid_address <= req_inv_q;
                rf_read_data       <= rd_commit ? req_snap_q : '0;
            end
        end
    end

    // CONTROL register, written at completion
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            control_q <= 4'b0000;
        end else if (ctrl_wr) begin
            control_q <= req_wdata_q;
        end
    end

    // FERR_N history for falling-edge detection
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            ferr_q <= 1'b1;
        end else begin
            ferr_q <= FERR_N;
        end
    end

    // saturating counters; a clear overrides any same-cycle increment
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            tx_beats_q    <= '0;
            rx_beats_q    <= '0;
            tx_stalls_q   <= '0;
            rx_stalls_q   <= '0;
            ferr_events_q <= '0;
            cycles_q      <= '0;
        end else if (cnt_clr) begin
            tx_beats_q    <= '0;
            rx_beats_q    <= '0;
            tx_stalls_q   <= '0;
            rx_stalls_q   <= '0;
            ferr_events_q <= '0;
            cycles_q      <= '0;
        end else begin
            tx_beats_q    <= sat_inc(tx_beats_q, tx_hs);
            rx_beats_q    <= sat_inc(rx_beats_q, rx_hs);
            tx_stalls_q   <= sat_inc(tx_stalls_q, tx_stall);
            rx_stalls_q   <= sat_inc(rx_stalls_q, rx_stall);
            ferr_events_q <= sat_inc(ferr_events_q, ferr_fall);
            cycles_q      <= sat_inc(cycles_q, link_up);
        end
    end

    assign ctrl_p_rst_n           = control_q[0];
    assign ctrl_init_cont_set     = control_q[1];
    assign ctrl_set_sleep         = control_q[2];
    assign ctrl_scrambler_disable = control_q[3];

endmodule
